// File: rtl/bitcoin_hash_pkg.sv
// Shared SHA-256 constants, types and round helpers for the nonce-search datapath.
package bitcoin_hash_pkg;

    typedef enum logic { MODE_WRITE_ALL = 1'b0, MODE_TARGET = 1'b1 } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_READ, ST_BLK1, ST_BLK2, ST_BLK3, ST_WRITE, ST_DONE
    } state_e;

    localparam logic [31:0] PAD_WORD = 32'h8000_0000;
    localparam logic [31:0] LEN_640  = 32'h0000_0280;
    localparam logic [31:0] LEN_256  = 32'h0000_0100;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rightrotate(input logic [31:0] x, input int unsigned r);
        return (x >> r) | (x << (32 - r));
    endfunction

    // One compression round on {a,b,c,d,e,f,g,h}, a in the top word.
    function automatic logic [255:0] sha256_op(input logic [255:0] st, input logic [31:0] w,
                                               input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = st;
        t1 = h + (rightrotate(e, 6) ^ rightrotate(e, 11) ^ rightrotate(e, 25))
               + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rightrotate(a, 2) ^ rightrotate(a, 13) ^ rightrotate(a, 22))
               + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [31:0] w_schedule(input logic [31:0] w0, input logic [31:0] w1,
                                               input logic [31:0] w9, input logic [31:0] w14);
        logic [31:0] s0, s1;
        s0 = rightrotate(w1, 7) ^ rightrotate(w1, 18) ^ (w1 >> 3);
        s1 = rightrotate(w14, 17) ^ rightrotate(w14, 19) ^ (w14 >> 10);
        return w0 + s0 + w9 + s1;
    endfunction

endpackage

// File: rtl/sha256_block.sv
// One SHA-256 compression: load cycle, 64 rounds, then digest valid with done for one cycle.
module sha256_block
    import bitcoin_hash_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] state_in,
    input  logic [511:0] block_in,
    output logic         done,
    output logic [255:0] digest_out
);
    logic [255:0] base_q, base_d, work_q, work_d;
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic [6:0]   cnt_q, cnt_d;
    logic         busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            work_q <= '0;
            w_q    <= '{default: '0};
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            base_q <= base_d;
            work_q <= work_d;
            w_q    <= w_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // w_q[0] is always W[t] for the current round; the window shifts down each round.
    always_comb begin
        base_d = base_q;
        work_d = work_q;
        w_d    = w_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            base_d = state_in;
            work_d = state_in;
            cnt_d  = '0;
            busy_d = 1'b1;
            for (int i = 0; i < 16; i++) w_d[i] = block_in[511 - 32*i -: 32];
        end else if (busy_q) begin
            if (cnt_q < 7'd64) begin
                work_d = sha256_op(work_q, w_q[0], K[cnt_q[5:0]]);
                for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
                w_d[15] = w_schedule(w_q[0], w_q[1], w_q[9], w_q[14]);
                cnt_d   = cnt_q + 7'd1;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    assign done = busy_q && (cnt_q == 7'd64);

    always_comb begin
        digest_out = '0;
        for (int i = 0; i < 8; i++)
            digest_out[255 - 32*i -: 32] = base_q[255 - 32*i -: 32] + work_q[255 - 32*i -: 32];
    end

endmodule

// File: rtl/bitcoin_nonce_search.sv
// Nonce sweep over a cached block-1 midstate: one shared sha256_block computes
// block 1 once, then block 2 and the outer hash for every nonce.
module bitcoin_nonce_search
    import bitcoin_hash_pkg::*;
#(
    parameter int NUM_NONCES = 16,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [31:0]       nonce_base,
    input  logic [31:0]       target,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    output logic              done,
    output logic              found,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);
    localparam logic [16:0] LAST_IDX = 17'(NUM_NONCES - 1);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [31:0]       base_q, base_d, target_q, target_d, h0_q, h0_d;
    logic [ADDR_W-1:0] msg_addr_q, msg_addr_d, out_addr_q, out_addr_d;
    logic [31:0]       hdr_q [19];
    logic [31:0]       hdr_d [19];
    logic [4:0]        rd_cnt_q, rd_cnt_d;
    logic [16:0]       idx_q, idx_d;
    logic [255:0]      mid_q, mid_d, dgst_q, dgst_d;
    logic              wr_step_q, wr_step_d, found_q, found_d, blk_start_q, blk_start_d;

    logic              blk_done;
    logic [255:0]      blk_state, blk_digest;
    logic [511:0]      blk_words;
    logic [31:0]       nonce;
    logic              hit, last;

    assign nonce   = base_q + 32'(idx_q);
    assign hit     = (mode_q == MODE_TARGET) && (h0_q < target_q);
    assign last    = (idx_q == LAST_IDX);
    assign mem_clk = clk;
    assign found   = found_q;

    sha256_block u_blk (
        .clk        (clk),
        .rst        (reset),
        .start      (blk_start_q),
        .state_in   (blk_state),
        .block_in   (blk_words),
        .done       (blk_done),
        .digest_out (blk_digest)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_READ;
            ST_READ:  if (rd_cnt_q == 5'd19) state_d = ST_BLK1;
            ST_BLK1:  if (blk_done) state_d = ST_BLK2;
            ST_BLK2:  if (blk_done) state_d = ST_BLK3;
            ST_BLK3:  if (blk_done) state_d = ST_WRITE;
            ST_WRITE: if (hit) state_d = wr_step_q ? ST_DONE : ST_WRITE;
                      else     state_d = last ? ST_DONE : ST_BLK2;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= MODE_WRITE_ALL;
            base_q      <= '0;
            target_q    <= '0;
            h0_q        <= '0;
            msg_addr_q  <= '0;
            out_addr_q  <= '0;
            hdr_q       <= '{default: '0};
            rd_cnt_q    <= '0;
            idx_q       <= '0;
            mid_q       <= '0;
            dgst_q      <= '0;
            wr_step_q   <= 1'b0;
            found_q     <= 1'b0;
            blk_start_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            base_q      <= base_d;
            target_q    <= target_d;
            h0_q        <= h0_d;
            msg_addr_q  <= msg_addr_d;
            out_addr_q  <= out_addr_d;
            hdr_q       <= hdr_d;
            rd_cnt_q    <= rd_cnt_d;
            idx_q       <= idx_d;
            mid_q       <= mid_d;
            dgst_q      <= dgst_d;
            wr_step_q   <= wr_step_d;
            found_q     <= found_d;
            blk_start_q <= blk_start_d;
        end
    end

    always_comb begin
        mode_d     = mode_q;
        base_d     = base_q;
        target_d   = target_q;
        h0_d       = h0_q;
        msg_addr_d = msg_addr_q;
        out_addr_d = out_addr_q;
        hdr_d      = hdr_q;
        rd_cnt_d   = rd_cnt_q;
        idx_d      = idx_q;
        mid_d      = mid_q;
        dgst_d     = dgst_q;
        wr_step_d  = wr_step_q;
        found_d    = found_q;
        // The compressor is kicked in the first cycle of every block state.
        blk_start_d = (state_d != state_q) && (state_d inside {ST_BLK1, ST_BLK2, ST_BLK3});
        unique case (state_q)
            ST_IDLE: if (start) begin
                mode_d     = mode_e'(mode);
                base_d     = nonce_base;
                target_d   = target;
                msg_addr_d = message_addr;
                out_addr_d = output_addr;
                found_d    = 1'b0;
                idx_d      = '0;
                rd_cnt_d   = '0;
                wr_step_d  = 1'b0;
            end
            ST_READ: begin
                rd_cnt_d = rd_cnt_q + 5'd1;
                if (rd_cnt_q != 5'd0) hdr_d[rd_cnt_q - 5'd1] = mem_read_data;
            end
            ST_BLK1: if (blk_done) mid_d = blk_digest;
            ST_BLK2: if (blk_done) dgst_d = blk_digest;
            ST_BLK3: if (blk_done) h0_d = blk_digest[255:224];
            ST_WRITE: begin
                if (hit) begin
                    wr_step_d = 1'b1;
                    found_d   = wr_step_q;
                end else if (!last) begin
                    idx_d = idx_q + 17'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        blk_state = IV;
        blk_words = '0;
        unique case (state_q)
            ST_BLK1: for (int i = 0; i < 16; i++) blk_words[511 - 32*i -: 32] = hdr_q[i];
            ST_BLK2: begin
                blk_state = mid_q;
                blk_words = {hdr_q[16], hdr_q[17], hdr_q[18], nonce, PAD_WORD, 320'd0, LEN_640};
            end
            ST_BLK3: blk_words = {dgst_q, PAD_WORD, 192'd0, LEN_256};
            default: ;
        endcase
    end

    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        done           = 1'b0;
        unique case (state_q)
            ST_READ: if (rd_cnt_q < 5'd19) mem_addr = msg_addr_q + ADDR_W'(rd_cnt_q);
            ST_WRITE: begin
                if (mode_q == MODE_WRITE_ALL) begin
                    mem_we         = 1'b1;
                    mem_addr       = out_addr_q + ADDR_W'(idx_q);
                    mem_write_data = h0_q;
                end else if (hit) begin
                    mem_we         = 1'b1;
                    mem_addr       = out_addr_q + ADDR_W'(wr_step_q);
                    mem_write_data = wr_step_q ? h0_q : nonce;
                end else if (last) begin
                    mem_we         = 1'b1;
                    mem_addr       = out_addr_q;
                    mem_write_data = 32'hFFFF_FFFF;
                end
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bitcoin_nonce_search.sv
// Self-checking bench for bitcoin_nonce_search with an independent SHA-256 reference model.
module tb_bitcoin_nonce_search;

    localparam int          N        = 16;
    localparam logic [15:0] MSG_ADDR = 16'h0100;
    localparam logic [15:0] OUT_ADDR = 16'h0800;

    localparam logic [255:0] TB_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] TB_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic        clk = 1'b0;
    logic        reset, start, mode;
    logic [31:0] nonce_base, target;
    logic [15:0] message_addr, output_addr;
    logic        done, found, mem_clk, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data, mem_read_data;

    logic [31:0] mem [0:65535];
    logic [31:0] hdr [19];
    logic [47:0] exp_q[$];
    logic [47:0] got_q[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    bitcoin_nonce_search #(.NUM_NONCES(N), .ADDR_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .nonce_base     (nonce_base),
        .target         (target),
        .message_addr   (message_addr),
        .output_addr    (output_addr),
        .done           (done),
        .found          (found),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Clock, cycle counter, synchronous-read memory and write monitor.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge mem_clk) mem_read_data <= mem[mem_addr];
    always @(negedge clk) if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_write_data});

    function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
        return (x >> r) | (x << (32 - r));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = st[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TB_K[i] + w[i];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = st[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [255:0] model_mid();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = hdr[i];
        return compress(TB_IV, b);
    endfunction

    function automatic logic [31:0] model_h0(input logic [255:0] mid, input logic [31:0] n);
        logic [255:0] d, h;
        d = compress(mid, {hdr[16], hdr[17], hdr[18], n, 32'h8000_0000, 320'd0, 32'h0000_0280});
        h = compress(TB_IV, {d, 32'h8000_0000, 192'd0, 32'h0000_0100});
        return h[255:224];
    endfunction

    task automatic load_header(input bit seq);
        for (int i = 0; i < 19; i++) begin
            hdr[i] = seq ? 32'h0123_4567 + 32'(i) : $urandom;
            mem[MSG_ADDR + 16'(i)] = hdr[i];
        end
    endtask

    // Drives one start and waits for done; lat = -1 if done never arrives.
    task automatic run_search(input logic m, input logic [31:0] base, input logic [31:0] tgt,
                              input bit noisy, output int lat, output logic fnd);
        int c0;
        lat = -1;
        fnd = 1'bx;
        @(negedge clk);
        mode = m; nonce_base = base; target = tgt; start = 1'b1;
        c0 = cyc;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat   = cyc - c0;
                fnd   = found;
                start = noisy;
                break;
            end
            start = noisy && ($urandom_range(0, 15) == 0);
            if (noisy) begin
                mode = 1'($urandom_range(0, 1)); nonce_base = $urandom; target = $urandom;
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, expected 0", done); end
        vectors++; if (found !== 1'b0) begin miscompares++; $display("FAIL reset_found: got %b, expected 0", found); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b, expected 0", mem_we); end
        vectors++; if (mem_addr !== 16'h0) begin miscompares++; $display("FAIL reset_addr: got %h, expected 0", mem_addr); end
        vectors++; if (mem_write_data !== 32'h0) begin miscompares++; $display("FAIL reset_wdata: got %h, expected 0", mem_write_data); end
    endtask

    task automatic test_write_all(input logic [31:0] base, input bit noisy);
        logic [255:0] mid;
        logic [47:0]  e, g;
        int           lat;
        logic         fnd;
        mid = model_mid();
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back({OUT_ADDR + 16'(i), model_h0(mid, base + 32'(i))});
        run_search(1'b0, base, 32'h0, noisy, lat, fnd);
        vectors++;
        if (lat !== 87 + 133 * N) begin miscompares++; $display("FAIL wa_latency: got %0d, expected %0d", lat, 87 + 133 * N); end
        vectors++;
        if (fnd !== 1'b0) begin miscompares++; $display("FAIL wa_found: got %b, expected 0", fnd); end
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++; $display("FAIL wa_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            vectors++;
            if (g !== e) begin miscompares++; $display("FAIL wa_write: got addr/data %h, expected %h", g, e); end
        end
        if (noisy) begin
            // The start asserted in the DONE cycle must not launch another search.
            repeat (5) @(negedge clk);
            vectors++;
            if (mem_addr !== 16'h0 || done !== 1'b0) begin
                miscompares++; $display("FAIL done_cycle_start: got addr %h done %b, expected 0 0", mem_addr, done);
            end
        end
    endtask

    task automatic test_target(input logic [31:0] tgt);
        logic [255:0] mid;
        logic [31:0]  base, n, h;
        logic [47:0]  e, g;
        int           hit_idx, lat;
        logic         fnd;
        base = $urandom;
        mid = model_mid();
        hit_idx = -1;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < N; i++) begin
            n = base + 32'(i);
            h = model_h0(mid, n);
            if (h < tgt) begin
                exp_q.push_back({OUT_ADDR, n});
                exp_q.push_back({OUT_ADDR + 16'd1, h});
                hit_idx = i;
                break;
            end
        end
        if (hit_idx < 0) exp_q.push_back({OUT_ADDR, 32'hFFFF_FFFF});
        run_search(1'b1, base, tgt, 1'b0, lat, fnd);
        vectors++;
        if (hit_idx >= 0) begin
            if (lat !== 221 + 133 * hit_idx) begin
                miscompares++; $display("FAIL tgt_latency: got %0d, expected %0d", lat, 221 + 133 * hit_idx);
            end
        end else if (lat < 0) begin
            miscompares++; $display("FAIL tgt_timeout: got no done, expected done");
        end
        vectors++;
        if (fnd !== (hit_idx >= 0)) begin miscompares++; $display("FAIL tgt_found: got %b, expected %b", fnd, hit_idx >= 0); end
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++; $display("FAIL tgt_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            vectors++;
            if (g !== e) begin miscompares++; $display("FAIL tgt_write: got addr/data %h, expected %h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] mid;
        logic [47:0]  e, g;
        mid = model_mid();
        exp_q.delete(); got_q.delete();
        // Nonce i is written 219 + 133*i cycles after start; only those before cycle 500 land.
        for (int i = 0; i < N; i++)
            if (219 + 133 * i < 500) exp_q.push_back({OUT_ADDR + 16'(i), model_h0(mid, 32'(i))});
        @(negedge clk);
        mode = 1'b0; nonce_base = 32'h0; target = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL midrst_we: got %b, expected 0", mem_we); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_done: got %b, expected 0", done); end
        vectors++; if (mem_addr !== 16'h0) begin miscompares++; $display("FAIL midrst_addr: got %h, expected 0", mem_addr); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++; $display("FAIL midrst_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            vectors++;
            if (g !== e) begin miscompares++; $display("FAIL midrst_write: got addr/data %h, expected %h", g, e); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        nonce_base = '0; target = '0;
        message_addr = MSG_ADDR; output_addr = OUT_ADDR;
        test_reset();
        load_header(1'b1);
        test_write_all(32'h0000_0000, 1'b0);
        test_target(32'hFFFF_FFFF);
        test_target(32'h0000_0000);
        load_header(1'b0);
        test_target(32'h2000_0000);
        test_write_all(32'hFFFF_FFFE, 1'b0);
        test_write_all($urandom, 1'b1);
        test_reset_mid();
        test_write_all(32'h0000_0000, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
